mmu_decode: RTL

Load-return and MMIO-access stage that sits directly downstream of `mmu_encode` and the four byte-wide block RAMs. It captures the stage-2 access attributes and undoes the byte rotation that `mmu_encode` applied, returning data with load-width zero/sign extension. It also handles every access whose address has the MMIO bit set, through a valid/ready request channel. While an MMIO access is outstanding it stalls the pipeline, and it signals a fault if the MMIO response times out.

---
 rtl/microcode_pkg.sv | 39 +++
 rtl/mmu_decode_load_extend.sv | 20 ++
 rtl/mmu_decode.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/microcode_pkg.sv
// Stage-2 control-word fields consumed by the memory return stage, plus the
// access-width type and helpers shared by the load/MMIO return path.
package microcode;

   typedef enum logic [1:0] {
      MW_BYTE = 2'd0,
      MW_HALF = 2'd1,
      MW_WORD = 2'd2
   } mem_width_e;

   typedef struct packed {
      logic mcs2_mem_re;
      logic mcs2_mem_we;
      logic mcs2_enable_byte1;
      logic mcs2_enable_upper_half;
      logic mcs2_load_unsigned;
   } microcode_t;

   localparam int unsigned WIDTH = $bits(microcode_t);

   function automatic mem_width_e access_width(input logic en_byte1, input logic en_upper);
      if (!en_byte1) return MW_BYTE;
      if (!en_upper) return MW_HALF;
      return MW_WORD;
   endfunction

   // Inverse of the byte rotation applied on the way into the RAMs.
   function automatic logic [31:0] unrotate(input logic [31:0] d, input logic [1:0] align);
      logic [31:0] r;
      case (align)
         2'b01:   r = {d[7:0], d[31:8]};
         2'b10:   r = {d[15:0], d[31:16]};
         2'b11:   r = {d[23:0], d[31:24]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mmu_decode_load_extend.sv
// Zero/sign extension of a right-justified load value to 32 bits.
module load_extend
   import microcode::*;
(
   input  logic [31:0] data_i,
   input  mem_width_e  width_i,
   input  logic        is_unsigned_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (width_i)
         MW_BYTE: data_o = {{24{~is_unsigned_i & data_i[7]}}, data_i[7:0]};
         MW_HALF: data_o = {{16{~is_unsigned_i & data_i[15]}}, data_i[15:0]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/mmu_decode.sv
// Load-return and MMIO-access stage: un-rotates and extends RAM load data, and
// runs MMIO accesses over a valid/ready channel, stalling the pipe meanwhile.
module mmu_decode
   import microcode::*;
#(
   parameter int unsigned MMIO_ADDR_START_BIT = 31,
   parameter int unsigned MMIO_TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       microcode_s2,
   input  logic [31:0]            addr,
   input  logic [31:0]            data_in,
   input  logic [31:0]            physical_data_out,
   output logic                   mmio_req_valid,
   input  logic                   mmio_req_ready,
   output logic                   mmio_req_we,
   output logic [31:0]            mmio_addr,
   output logic [31:0]            mmio_wdata,
   input  logic                   mmio_resp_valid,
   input  logic [31:0]            mmio_resp_data,
   output logic                   stall,
   output logic [31:0]            data_out,
   output logic                   data_valid,
   output logic                   fault
);

   localparam int unsigned CntW = (MMIO_TIMEOUT_CYCLES > 2) ? $clog2(MMIO_TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MMIO_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} mmio_state_e;

   microcode_t mc;
   logic       load, store, is_mmio, mmio_start, ram_fire;
   mem_width_e acc_width;

   assign mc        = microcode_t'(microcode_s2);
   assign load      = mc.mcs2_mem_re;
   assign store     = mc.mcs2_mem_we;
   assign is_mmio   = addr[MMIO_ADDR_START_BIT];
   assign acc_width = access_width(mc.mcs2_enable_byte1, mc.mcs2_enable_upper_half);

   mmio_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     maddr_q, maddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            we_q, we_d;
   mem_width_e      mwidth_q, mwidth_d;
   logic            muns_q, muns_d;
   logic            fault_q, fault_d;

   logic            ram_pend_q, ram_pend_d;
   logic [1:0]      align_q, align_d;
   mem_width_e      rwidth_q, rwidth_d;
   logic            runs_q, runs_d;

   assign mmio_start = (state_q == StIdle) & (load | store) & is_mmio;
   // rst_n term keeps the combinational IDLE stall low while reset is held.
   assign stall      = rst_n & (mmio_start | (state_q == StReq) | (state_q == StWait));
   assign ram_fire   = load & ~is_mmio & ~stall;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      maddr_d  = maddr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      we_d     = we_q;
      mwidth_d = mwidth_q;
      muns_d   = muns_q;
      fault_d  = fault_q;
      case (state_q)
         StIdle: begin
            if (mmio_start) begin
               state_d  = StReq;
               maddr_d  = addr;
               wdata_d  = data_in;
               we_d     = store;
               mwidth_d = acc_width;
               muns_d   = mc.mcs2_load_unsigned;
               fault_d  = 1'b0;
               rdata_d  = '0;
            end
         end
         StReq: begin
            if (mmio_req_ready) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // A response on the final wait cycle beats the timeout.
            if (mmio_resp_valid) begin
               state_d = StDone;
               rdata_d = mmio_resp_data;
            end else if (cnt_q == CntLast) begin
               state_d = StDone;
               rdata_d = '0;
               fault_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            fault_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      ram_pend_d = ram_fire;
      align_d    = align_q;
      rwidth_d   = rwidth_q;
      runs_d     = runs_q;
      if (ram_fire) begin
         align_d  = addr[1:0];
         rwidth_d = acc_width;
         runs_d   = mc.mcs2_load_unsigned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         maddr_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         mwidth_q   <= MW_BYTE;
         muns_q     <= 1'b0;
         fault_q    <= 1'b0;
         ram_pend_q <= 1'b0;
         align_q    <= '0;
         rwidth_q   <= MW_BYTE;
         runs_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         maddr_q    <= maddr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         we_q       <= we_d;
         mwidth_q   <= mwidth_d;
         muns_q     <= muns_d;
         fault_q    <= fault_d;
         ram_pend_q <= ram_pend_d;
         align_q    <= align_d;
         rwidth_q   <= rwidth_d;
         runs_q     <= runs_d;
      end
   end

   logic        in_done, done_load;
   logic [31:0] ext_in, ext_out;
   mem_width_e  ext_width;
   logic        ext_uns;

   assign in_done   = (state_q == StDone);
   assign done_load = in_done & ~we_q;

   // DONE and a RAM return never overlap, so one extender serves both.
   always_comb begin
      ext_in    = unrotate(physical_data_out, align_q);
      ext_width = rwidth_q;
      ext_uns   = runs_q;
      if (in_done) begin
         ext_in    = rdata_q;
         ext_width = mwidth_q;
         ext_uns   = muns_q;
      end
   end

   load_extend u_load_extend (
      .data_i        (ext_in),
      .width_i       (ext_width),
      .is_unsigned_i (ext_uns),
      .data_o        (ext_out)
   );

   assign data_valid     = ram_pend_q | done_load;
   assign data_out       = data_valid ? ext_out : '0;
   assign fault          = in_done & fault_q;
   assign mmio_req_valid = (state_q == StReq);
   assign mmio_req_we    = we_q;
   assign mmio_addr      = maddr_q;
   assign mmio_wdata     = wdata_q;

endmodule
